// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers.
// A grant lasts one packet, capped by MAX_BURST words or TIMEOUT idle cycles.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATASIZE  = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_r;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   last_ptr_r;
  logic [BW-1:0]   burst_cnt_r;
  logic [IW-1:0]   idle_cnt_r;
  logic            busy_r;

  logic            pick_ok_s;
  logic [GW-1:0]   pick_id_s;
  logic            fire_s;
  logic            idle_s;
  logic            rel_s;

  // Handshake qualifiers for the current grantee; idle cycles ignore wfull stalls
  assign fire_s = (state_r == GRANT) & req_valid[grant_r] & ~wfull;
  assign idle_s = (state_r == GRANT) & ~req_valid[grant_r] & ~wfull;
  assign rel_s  = (fire_s & (req_last[grant_r] | (burst_cnt_r == BURST_LAST)))
                | (idle_s & (idle_cnt_r == IDLE_LAST));

  assign grant_id = grant_r;
  assign busy     = busy_r;

  // Round-robin search starting just after the last released requester
  always_comb begin : rr_pick
    logic [GW-1:0] idx_v;
    idx_v     = '0;
    pick_ok_s = 1'b0;
    pick_id_s = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_v = GW'((int'(last_ptr_r) + i) % NREQ);
      if (!pick_ok_s && req_valid[idx_v]) begin
        pick_ok_s = 1'b1;
        pick_id_s = idx_v;
      end else begin
        pick_ok_s = pick_ok_s;
      end
    end
  end

  // Write-port mux; ready and winc follow wfull combinationally so no word is lost
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (state_r == GRANT) begin
      req_ready[grant_r] = ~wfull;
      winc               = fire_s;
      wdata              = req_data[int'(grant_r)*DATASIZE +: DATASIZE];
    end else begin
      req_ready = '0;
    end
  end

  // Grant FSM with burst and idle-timeout counters
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      last_ptr_r  <= GW'(NREQ - 1);
      burst_cnt_r <= '0;
      idle_cnt_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_ok_s) begin
            state_r     <= GRANT;
            grant_r     <= pick_id_s;
            busy_r      <= 1'b1;
            burst_cnt_r <= '0;
            idle_cnt_r  <= '0;
          end
        end
        GRANT: begin
          if (rel_s) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            last_ptr_r <= grant_r;
          end
          if (fire_s) begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
            idle_cnt_r  <= '0;
          end else if (idle_s) begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences
// for burst limit, wfull stall, idle timeout and asynchronous reset.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .MAX_BURST(16), .TIMEOUT(8)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  ready;
    logic        busy;
    logic [1:0]  gid;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_o(input string nm, input logic w, input logic [7:0] d,
                       input logic [3:0] r, input logic b, input logic [1:0] g);
    chk({nm, "_winc"},  32'(winc),      32'(w));
    chk({nm, "_wdata"}, 32'(wdata),     32'(d));
    chk({nm, "_ready"}, 32'(req_ready), 32'(r));
    chk({nm, "_busy"},  32'(busy),      32'(b));
    chk({nm, "_gid"},   32'(grant_id),  32'(g));
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
    @(negedge wclk);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    wfull     = f;
    #1;
  endtask

  task automatic reset_dut();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 32'h0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit r2done;
    logic [7:0] wd_log[$];
    logic [1:0] g_log[$];
    logic [7:0] exp_d;
    logic [1:0] exp_g;

    wrst_n    = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 32'h0;
    wfull     = 1'b0;

    // 3-word packet on req0, then all four requesters with 1-word packets
    tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 32'h000000A1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 32'h000000A1, 1'b0, 1'b1, 8'hA1, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 32'h000000A2, 1'b0, 1'b1, 8'hA2, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 32'h000000A3, 1'b0, 1'b1, 8'hA3, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b1, 8'h40, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b1, 8'h41, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
    tbl[10] = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b1, 8'h42, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
    tbl[12] = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b1, 8'h43, 4'b1000, 1'b1, 2'd3};
    tbl[13] = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3};
    tbl[14] = '{1'b0, 4'b1111, 4'b1111, 32'h43424140, 1'b0, 1'b1, 8'h40, 4'b0001, 1'b1, 2'd0};

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) reset_dut();
      drive(tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].wfull);
      exp_o($sformatf("vec%0d", i), tbl[i].winc, tbl[i].wdata, tbl[i].ready, tbl[i].busy, tbl[i].gid);
    end

    // Burst limit: req1 streams 32 words, req2 holds a 1-word packet
    reset_dut();
    k = 0;
    r2done = 1'b0;
    for (int cyc = 0; cyc < 200 && !(k == 32 && r2done); cyc++) begin
      @(negedge wclk);
      req_valid = {1'b0, ~r2done, (k < 32), 1'b0};
      req_last  = 4'b0100;
      req_data  = {8'h00, 8'h77, 8'(k), 8'h00};
      wfull     = 1'b0;
      #1;
      if (winc) begin
        wd_log.push_back(wdata);
        g_log.push_back(grant_id);
      end
      if (req_valid[1] && req_ready[1]) k++;
      if (req_valid[2] && req_ready[2]) r2done = 1'b1;
    end
    chk("t3_done", 32'((k == 32) && r2done), 32'd1);
    chk("t3_count", 32'(wd_log.size()), 32'd33);
    for (int i = 0; i < 33 && i < wd_log.size(); i++) begin
      if (i < 16) begin
        exp_d = 8'(i);
        exp_g = 2'd1;
      end else if (i == 16) begin
        exp_d = 8'h77;
        exp_g = 2'd2;
      end else begin
        exp_d = 8'(i - 1);
        exp_g = 2'd1;
      end
      chk($sformatf("t3_data%0d", i), 32'(wd_log[i]), 32'(exp_d));
      chk($sformatf("t3_gid%0d", i),  32'(g_log[i]),  32'(exp_g));
    end

    // wfull stall on req3 mid-packet, rising together with valid
    reset_dut();
    drive(4'b1000, 4'b0000, 32'hD0000000, 1'b0);
    exp_o("t4_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    drive(4'b1000, 4'b0000, 32'hD0000000, 1'b0);
    exp_o("t4_w0", 1'b1, 8'hD0, 4'b1000, 1'b1, 2'd3);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1000, 4'b0000, 32'hD1000000, 1'b1);
      exp_o($sformatf("t4_stall%0d", i), 1'b0, 8'hD1, 4'b0000, 1'b1, 2'd3);
    end
    drive(4'b1000, 4'b0000, 32'hD1000000, 1'b0);
    exp_o("t4_w1", 1'b1, 8'hD1, 4'b1000, 1'b1, 2'd3);
    drive(4'b1000, 4'b0000, 32'hD2000000, 1'b0);
    exp_o("t4_w2", 1'b1, 8'hD2, 4'b1000, 1'b1, 2'd3);
    drive(4'b1000, 4'b1000, 32'hD3000000, 1'b0);
    exp_o("t4_w3", 1'b1, 8'hD3, 4'b1000, 1'b1, 2'd3);
    drive(4'b0000, 4'b0000, 32'h00000000, 1'b0);
    exp_o("t4_rel", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);

    // Idle timeout: req0 stalls after two words, req1 waits
    reset_dut();
    drive(4'b0011, 4'b0010, 32'h0000B0E0, 1'b0);
    exp_o("t5_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    drive(4'b0011, 4'b0010, 32'h0000B0E0, 1'b0);
    exp_o("t5_w0", 1'b1, 8'hE0, 4'b0001, 1'b1, 2'd0);
    drive(4'b0011, 4'b0010, 32'h0000B0E1, 1'b0);
    exp_o("t5_w1", 1'b1, 8'hE1, 4'b0001, 1'b1, 2'd0);
    for (int i = 0; i < 8; i++) begin
      drive(4'b0010, 4'b0010, 32'h0000B000, 1'b0);
      exp_o($sformatf("t5_idle%0d", i), 1'b0, 8'h00, 4'b0001, 1'b1, 2'd0);
    end
    drive(4'b0010, 4'b0010, 32'h0000B000, 1'b0);
    exp_o("t5_rel", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    drive(4'b0010, 4'b0010, 32'h0000B000, 1'b0);
    exp_o("t5_next", 1'b1, 8'hB0, 4'b0010, 1'b1, 2'd1);

    // Asynchronous reset in the middle of a req2 packet
    reset_dut();
    drive(4'b0100, 4'b0000, 32'h00C00000, 1'b0);
    exp_o("t6_arb", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    drive(4'b0100, 4'b0000, 32'h00C00000, 1'b0);
    exp_o("t6_w0", 1'b1, 8'hC0, 4'b0100, 1'b1, 2'd2);
    drive(4'b0101, 4'b0000, 32'h00C100A0, 1'b0);
    exp_o("t6_w1", 1'b1, 8'hC1, 4'b0100, 1'b1, 2'd2);
    #2;
    wrst_n = 1'b0;
    #1;
    exp_o("t6_rst", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    repeat (2) @(negedge wclk);
    req_last = 4'b0001;
    wrst_n   = 1'b1;
    #1;
    exp_o("t6_idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    drive(4'b0101, 4'b0001, 32'h00C100A0, 1'b0);
    exp_o("t6_g0", 1'b1, 8'hA0, 4'b0001, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
